// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD operand fetch slice.
// Lane count, lane width, fetch state encoding and index widths.
package simd_pkg;

    localparam int SIMD_LANES = 4;
    localparam int SIMD_XLEN  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int IDX_W      = $clog2(SIMD_LANES);
    localparam int VL_W       = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_e;

    typedef logic [IDX_W-1:0] lane_idx_t;
    typedef logic [VL_W-1:0]  vl_t;

endpackage

// File: rtl/simd_lane_buffer.sv
// Per-operand lane buffer: one register per lane plus capture logic.
// Writeback snooping is compiled in when SIMD_FETCH_SNOOP_EN is defined.
module simd_lane_buffer
    import simd_pkg::*;
#(
    parameter int LANES = SIMD_LANES,
    parameter int XLEN  = SIMD_XLEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      cap_en,
    input  logic [$clog2(LANES)-1:0]  cap_idx,
    input  logic [REG_ADDR_W-1:0]     cap_addr,
    input  logic [XLEN-1:0]           cap_data,
    input  logic                      snoop_act,
    input  logic                      wb_en,
    input  logic [REG_ADDR_W-1:0]     wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    output logic [LANES*XLEN-1:0]     lanes
);

    localparam int IW = $clog2(LANES);

    logic [XLEN-1:0] data_q [LANES];
    logic [XLEN-1:0] cap_val;

`ifdef SIMD_FETCH_SNOOP_EN
    logic [REG_ADDR_W-1:0] addr_q [LANES];
    logic [LANES-1:0]      vld_q;

    // A write landing on the address read this cycle beats the stale port data.
    assign cap_val = (wb_en && wb_addr == cap_addr) ? wb_data : cap_data;

    // Remember which register each captured lane came from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < LANES; i++) addr_q[i] <= '0;
        end else if (clear) begin
            vld_q <= '0;
            for (int i = 0; i < LANES; i++) addr_q[i] <= '0;
        end else if (cap_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (cap_idx == IW'(i)) begin
                    vld_q[i]  <= 1'b1;
                    addr_q[i] <= cap_addr;
                end
            end
        end
    end
`else
    logic unused_snoop;

    assign cap_val      = cap_data;
    assign unused_snoop = ^{snoop_act, wb_en, wb_addr, wb_data, cap_addr};
`endif

    // Capture the current lane; refresh already-captured lanes on a matching write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) data_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (cap_en && cap_idx == IW'(i)) begin
                    data_q[i] <= cap_val;
`ifdef SIMD_FETCH_SNOOP_EN
                end else if (snoop_act && wb_en && vld_q[i] &&
                             addr_q[i] == wb_addr) begin
                    data_q[i] <= wb_data;
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign lanes[g*XLEN +: XLEN] = data_q[g];
    end

endmodule

// File: rtl/simd_operand_fetch.sv
// Walks consecutive registers through the two register file read ports
// and presents packed operand vectors. Optional macro: SIMD_FETCH_SNOOP_EN.
module simd_operand_fetch
    import simd_pkg::*;
#(
    parameter int LANES = SIMD_LANES,
    parameter int XLEN  = SIMD_XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    input  logic [$clog2(LANES):0]   req_vl,
    input  logic                     req_splat,
    output logic [4:0]               rf_addr1,
    output logic [4:0]               rf_addr2,
    input  logic [XLEN-1:0]          rf_data1,
    input  logic [XLEN-1:0]          rf_data2,
    input  logic                     wb_en,
    input  logic [4:0]               wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*XLEN-1:0]    out_a,
    output logic [LANES*XLEN-1:0]    out_b,
    output logic [$clog2(LANES):0]   out_vl
);

    localparam int IW = $clog2(LANES);
    localparam int VW = IW + 1;
    localparam int AW = REG_ADDR_W;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [VW-1:0]   vl_q;
    logic            splat_q;
    logic [VW-1:0]   vl_eff;
    logic            accept;
    logic            last;
    logic            in_fetch;
    logic            snoop_act;

    // Zero or oversized lane counts mean a full vector.
    assign vl_eff    = (req_vl == '0 || req_vl > VW'(LANES)) ? VW'(LANES) : req_vl;
    assign accept    = req_valid && (state == IDLE);
    assign last      = ({1'b0, idx} == vl_q - VW'(1));
    assign in_fetch  = (state == FETCH);
    assign snoop_act = (state == FETCH) || (state == HOLD);
    assign out_vl    = vl_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: accept, walk vl lanes, wait for the consumer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = FETCH;
            FETCH:   if (last)      state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input reaches them combinationally.
    always_comb begin
        req_ready = 1'b0;
        out_valid = 1'b0;
        rf_addr1  = '0;
        rf_addr2  = '0;
        unique case (state)
            IDLE:  req_ready = 1'b1;
            FETCH: begin
                rf_addr1 = rs1_q + AW'(idx);
                rf_addr2 = splat_q ? rs2_q : rs2_q + AW'(idx);
            end
            HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Latch the request on accept and step the lane index during FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            vl_q    <= '0;
            splat_q <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            vl_q    <= vl_eff;
            splat_q <= req_splat;
        end else if (in_fetch) begin
            idx     <= idx + IW'(1);
        end
    end

    simd_lane_buffer #(.LANES(LANES), .XLEN(XLEN)) u_buf_a (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .cap_en    (in_fetch),
        .cap_idx   (idx),
        .cap_addr  (rf_addr1),
        .cap_data  (rf_data1),
        .snoop_act (snoop_act),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lanes     (out_a)
    );

    simd_lane_buffer #(.LANES(LANES), .XLEN(XLEN)) u_buf_b (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .cap_en    (in_fetch),
        .cap_idx   (idx),
        .cap_addr  (rf_addr2),
        .cap_data  (rf_data2),
        .snoop_act (snoop_act),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lanes     (out_b)
    );

endmodule

// File: tb/tb_simd_operand_fetch.sv
// Self-checking bench for simd_operand_fetch with a behavioural register file.
// Vector table plus hand-written backpressure, splat, snoop and reset sequences.
module tb_simd_operand_fetch;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_rs1;
    logic [4:0]   req_rs2;
    logic [2:0]   req_vl;
    logic         req_splat;
    logic [4:0]   rf_addr1;
    logic [4:0]   rf_addr2;
    logic [31:0]  rf_data1;
    logic [31:0]  rf_data2;
    logic         wb_en;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_a;
    logic [127:0] out_b;
    logic [2:0]   out_vl;

    logic [31:0]  rf [32];

    always #5 clk = ~clk;

    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];

    always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

    simd_operand_fetch #(.LANES(4), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_vl    (req_vl),
        .req_splat (req_splat),
        .rf_addr1  (rf_addr1),
        .rf_addr2  (rf_addr2),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_vl    (out_vl)
    );

    typedef struct {
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   vl;
        logic         splat;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [2:0]   evl;
    } vec_t;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [2:0]   vl;
    } exp_t;

    vec_t tab [6];
    vec_t vs;
    exp_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    // Issue one request and return once the DUT shows out_valid (or times out).
    task automatic fetch(input vec_t v, input string nm);
        exp_t       e;
        int         cyc;
        logic [4:0] e1;
        logic [4:0] e2;
        req_rs1   = v.rs1;
        req_rs2   = v.rs2;
        req_vl    = v.vl;
        req_splat = v.splat;
        req_valid = 1'b1;
        chk({nm, " req_ready"}, int'(req_ready), 1);
        e.a  = v.ea;
        e.b  = v.eb;
        e.vl = v.evl;
        sb.push_back(e);
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            if (cyc <= int'(v.evl)) begin
                e1 = v.rs1 + 5'(cyc - 1);
                e2 = v.splat ? v.rs2 : v.rs2 + 5'(cyc - 1);
                chk({nm, " rf_addr1"}, int'(rf_addr1), int'(e1));
                chk({nm, " rf_addr2"}, int'(rf_addr2), int'(e2));
            end
            step();
            cyc++;
        end
        chk({nm, " latency"}, cyc, int'(v.evl) + 1);
        e = sb.pop_front();
        chkv({nm, " out_a"}, out_a, e.a);
        chkv({nm, " out_b"}, out_b, e.b);
        chk({nm, " out_vl"}, int'(out_vl), int'(e.vl));
    endtask

    task automatic release_hold(input string nm);
        out_ready = 1'b1;
        step();
        chk({nm, " idle req_ready"}, int'(req_ready), 1);
        chk({nm, " idle out_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_vl    = '0;
        req_splat = 1'b0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;

        tab[0] = '{5'd4, 5'd8, 3'd4, 1'b0,
                   {32'h13, 32'h12, 32'h11, 32'h10},
                   {32'h23, 32'h22, 32'h21, 32'h20}, 3'd4};
        tab[1] = '{5'd30, 5'd31, 3'd3, 1'b0,
                   {32'h0, 32'h100, 32'h11F, 32'h11E},
                   {32'h0, 32'h101, 32'h100, 32'h11F}, 3'd3};
        tab[2] = '{5'd0, 5'd2, 3'd0, 1'b0,
                   {32'h103, 32'h102, 32'h101, 32'h100},
                   {32'h11, 32'h10, 32'h103, 32'h102}, 3'd4};
        tab[3] = '{5'd12, 5'd16, 3'd5, 1'b0,
                   {32'h10F, 32'h10E, 32'h10D, 32'h10C},
                   {32'h113, 32'h112, 32'h111, 32'h110}, 3'd4};
        tab[4] = '{5'd31, 5'd0, 3'd1, 1'b0,
                   {32'h0, 32'h0, 32'h0, 32'h11F},
                   {32'h0, 32'h0, 32'h0, 32'h100}, 3'd1};
        tab[5] = '{5'd6, 5'd3, 3'd2, 1'b1,
                   {32'h0, 32'h0, 32'h13, 32'h12},
                   {32'h0, 32'h0, 32'h103, 32'h103}, 3'd2};

        #12;
        chk("rst req_ready", int'(req_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chkv("rst out_a", out_a, '0);
        chkv("rst out_b", out_b, '0);
        chk("rst out_vl", int'(out_vl), 0);
        chk("rst rf_addr1", int'(rf_addr1), 0);
        chk("rst rf_addr2", int'(rf_addr2), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        for (int i = 0; i < 32; i++) wb_write(5'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) wb_write(5'(4 + i), 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) wb_write(5'(8 + i), 32'h20 + 32'(i));

        for (int i = 0; i < 6; i++) begin
            fetch(tab[i], $sformatf("vec%0d", i));
            release_hold($sformatf("vec%0d", i));
        end

        // Splat: r9 broadcast to every lane, address port 2 stays at r9.
        wb_write(5'd9, 32'hDEADBEEF);
        vs = '{5'd4, 5'd9, 3'd4, 1'b1,
               {32'h13, 32'h12, 32'h11, 32'h10},
               {4{32'hDEADBEEF}}, 3'd4};
        fetch(vs, "splat");
        release_hold("splat");
        wb_write(5'd9, 32'h21);

        // Backpressure: six stalled HOLD cycles.
        out_ready = 1'b0;
        fetch(tab[0], "bp");
        for (int k = 0; k < 6; k++) begin
            step();
            chk("bp out_valid", int'(out_valid), 1);
            chk("bp req_ready", int'(req_ready), 0);
            chkv("bp out_a", out_a, tab[0].ea);
            chkv("bp out_b", out_b, tab[0].eb);
            chk("bp out_vl", int'(out_vl), 4);
        end
        release_hold("bp");

        // Snoop: write r5 while lane 1 reads it, write r4 during HOLD.
        out_ready = 1'b0;
        req_rs1   = 5'd4;
        req_rs2   = 5'd8;
        req_vl    = 3'd4;
        req_splat = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("snoop lane1 addr", int'(rf_addr1), 5);
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h55;
        step();
        wb_en = 1'b0;
        step();
        step();
        chk("snoop out_valid", int'(out_valid), 1);
        wb_write(5'd4, 32'h44);
`ifdef SIMD_FETCH_SNOOP_EN
        chkv("snoop out_a", out_a, {32'h13, 32'h12, 32'h55, 32'h44});
`else
        chkv("snoop out_a", out_a, {32'h13, 32'h12, 32'h11, 32'h10});
`endif
        chkv("snoop out_b", out_b, {32'h23, 32'h22, 32'h21, 32'h20});
        release_hold("snoop");
        wb_write(5'd4, 32'h10);
        wb_write(5'd5, 32'h11);

        // Reset after lane 1 capture, then a clean request.
        req_rs1   = 5'd12;
        req_rs2   = 5'd16;
        req_vl    = 3'd4;
        req_splat = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid rst out_valid", int'(out_valid), 0);
        chk("mid rst req_ready", int'(req_ready), 1);
        chkv("mid rst out_a", out_a, '0);
        chkv("mid rst out_b", out_b, '0);
        chk("mid rst out_vl", int'(out_vl), 0);
        chk("mid rst rf_addr1", int'(rf_addr1), 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        fetch(tab[0], "post rst");
        release_hold("post rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_operand_fetch.md
# simd_operand_fetch

Reads vector operands out of the 32x32 register file through its two combinational read ports and hands them to the SIMD execute stage as packed lane vectors. A request names two base registers and a lane count. The block walks consecutive registers, one lane per cycle per port, and captures each lane into a buffer. It then presents both vectors with a valid/ready handshake. It sits between decode and the SIMD ALU and drives the register file's read_addr1/read_addr2.

## Interface
- LANES, 4: number of 32-bit lanes per vector operand (power of two, 2..8).
- XLEN, 32: lane width; must equal the register file data width.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  decode presents a fetch request.
- req_ready  out  1  block accepts the request; high only in IDLE.
- req_rs1  in  5  base register for operand A.
- req_rs2  in  5  base register for operand B.
- req_vl  in  $clog2(LANES)+1  active lane count; 0 or >LANES is treated as LANES.
- req_splat  in  1  operand B is the scalar register req_rs2, broadcast to all active lanes.
- rf_addr1  out  5  register file read_addr1.
- rf_addr2  out  5  register file read_addr2.
- rf_data1  in  XLEN  register file read_data1.
- rf_data2  in  XLEN  register file read_data2.
- wb_en, wb_addr[4:0], wb_data[XLEN-1:0]  in  writeback port, in parallel with the register file write port (snoop).
- out_valid  out  1  operand vectors are stable and valid.
- out_ready  in  1  execute stage consumes the operands.
- out_a  out  LANES*XLEN  operand A; lane i occupies bits [i*XLEN +: XLEN].
- out_b  out  LANES*XLEN  operand B, same packing.
- out_vl  out  $clog2(LANES)+1  effective lane count of the held operands.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE:
  - req_ready=1 and rf_addr1=rf_addr2=0.
  - On req_valid&&req_ready, latch rs1, rs2, effective vl and splat; clear the lane index; go to FETCH.
- FETCH, lane index i:
  - rf_addr1 = (rs1+i) mod 32.
  - rf_addr2 = splat ? rs2 : (rs2+i) mod 32.
  - Capture rf_data1 into A[i] and rf_data2 into B[i] at the clock edge.
  - When splat, B[i] captures the same register value in every cycle.
  - Increment i.
  - After lane vl-1 is captured, go to HOLD.
- HOLD:
  - out_valid=1.
  - out_a/out_b/out_vl are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- Lanes i>=vl are driven 0 in out_a/out_b.
- Lane buffers are cleared on accept.
- Register addresses wrap modulo 32; for example, rs1=30 with vl=4 reads r30, r31, r0, r1.
- Register 0 gets no special treatment.
- Reset at any time returns to IDLE, clears all buffers, the index and the latched fields, and drops out_valid.

## Timing
- Reset values: req_ready=1, out_valid=0, out_a=0, out_b=0, out_vl=0, rf_addr1=0, rf_addr2=0.
- The accept edge is cycle 0.
- FETCH occupies cycles 1..vl.
- out_valid rises after the edge that captures the last lane, so it is first visible vl+1 cycles after accept.
- HOLD lasts at least one cycle.
- Maximum throughput is one request per vl+2 cycles.
- No combinational path from out_ready to req_ready, or from req_valid to any output.
- rf_data is sampled in the same cycle its address is driven, relying on the register file's combinational read.

## Configuration
- SIMD_FETCH_SNOOP_EN defined:
  - A wb_en write whose wb_addr equals the address being read this cycle in FETCH captures wb_data instead of the stale rf_data.
  - A wb_en write that matches an already-captured lane address, in FETCH or HOLD, overwrites that lane buffer with wb_data.
  - Operands therefore reflect every write that completes before the output handshake.
  - Splat B updates all active lanes.
- SIMD_FETCH_SNOOP_EN undefined: wb_* inputs are ignored, and operands are the register values as of each lane's read cycle.

## Structure
- Shared package simd_pkg holds:
  - LANES and XLEN defaults.
  - The fetch state enum (IDLE/FETCH/HOLD).
  - The lane-index and vl typedefs.
  - REG_ADDR_W=5.
- One sub-module, simd_lane_buffer, instantiated once per operand. It holds LANES registers plus their latched register addresses, does per-lane capture, and contains the snoop compare and overwrite logic, which is compiled under the macro.

## Test plan
- Basic fetch:
  - Preload r4..r7=0x10..0x13 and r8..r11=0x20..0x23.
  - Request rs1=4, rs2=8, vl=4.
  - Expect out_valid 5 cycles after accept, out_a lanes = 0x10,0x11,0x12,0x13 and out_b lanes = 0x20,0x21,0x22,0x23.
- Wrap and partial:
  - Request rs1=30, rs2=31, vl=3.
  - Expect reads r30,r31,r0 and r31,r0,r1, lane 3 = 0, out_vl=3.
- Splat:
  - Preload r9=0xDEADBEEF.
  - Request rs2=9, splat=1, vl=4.
  - Expect every out_b lane = 0xDEADBEEF and rf_addr2 constant at 9 during FETCH.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in HOLD.
  - Expect outputs stable and req_ready=0; release, then expect IDLE and req_ready=1 the next cycle.
- Snoop (macro on):
  - Write r5=0x55 via wb while lane 1 (r5) is being read, and write r4=0x44 during HOLD.
  - Expect out_a lane 1 = 0x55 and lane 0 = 0x44.
  - With the macro off, expect the old values.
- Reset mid-FETCH:
  - Assert reset after lane 1 is captured.
  - Expect out_valid=0, req_ready=1, buffers zero, and a fresh request completing normally afterwards.
